// File: rtl/bus_arbiter_if.sv
// Memory request bus shared by the instruction, data and merged ports.
// master drives the request; slave returns read data and completion.
interface bus_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port to one-port memory arbiter, one transaction in flight.
// Ties go round-robin (RR=1) or to the data port (RR=0).
module bus_arbiter #(
  parameter int RR = 1
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.slave   imemory,
  bus_arbiter_if.slave   dmemory,
  bus_arbiter_if.master  memory
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_d_q;
  logic        gnt_i, gnt_d;
  logic        instr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Pick the winner among the currently requesting ports.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (imemory.valid && dmemory.valid) begin
      if (RR != 0 && last_d_q)
        gnt_i = 1'b1;
      else
        gnt_d = 1'b1;
    end else begin
      gnt_i = imemory.valid;
      gnt_d = dmemory.valid;
    end
  end

  // Next state: grant from IDLE, retire on memory completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_i)
          state_d = IBUSY;
        else if (gnt_d)
          state_d = DBUSY;
      end
      IBUSY,
      DBUSY: begin
        if (memory.ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, last grant and the captured request fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      instr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_i) begin
        last_d_q <= 1'b0;
        instr_q  <= imemory.instr;
        addr_q   <= imemory.addr;
        wdata_q  <= imemory.wdata;
        wstrb_q  <= imemory.wstrb;
      end else if (state_q == IDLE && gnt_d) begin
        last_d_q <= 1'b1;
        instr_q  <= dmemory.instr;
        addr_q   <= dmemory.addr;
        wdata_q  <= dmemory.wdata;
        wstrb_q  <= dmemory.wstrb;
      end
    end
  end

  // Merged request comes straight from registers.
  always_comb begin
    memory.valid = (state_q != IDLE);
    memory.instr = instr_q;
    memory.addr  = addr_q;
    memory.wdata = wdata_q;
    memory.wstrb = wstrb_q;
  end

  // Read data is broadcast; completion routed to the owner only.
  always_comb begin
    imemory.rdata = memory.rdata;
    dmemory.rdata = memory.rdata;
    imemory.ready = memory.ready && (state_q == IBUSY);
    dmemory.ready = memory.ready && (state_q == DBUSY);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Random and directed bench for bus_arbiter, RR=1 and RR=0 side by side.
// A transaction-level model predicts every output each cycle.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv, ii, dv, di, mr;
  logic [31:0] ia, iw, da, dw, mrd;
  logic [3:0]  istb, dstb;

  bus_arbiter_if imem0 ();
  bus_arbiter_if dmem0 ();
  bus_arbiter_if mem0 ();
  bus_arbiter_if imem1 ();
  bus_arbiter_if dmem1 ();
  bus_arbiter_if mem1 ();

  assign imem0.valid = iv;
  assign imem0.instr = ii;
  assign imem0.addr  = ia;
  assign imem0.wdata = iw;
  assign imem0.wstrb = istb;
  assign dmem0.valid = dv;
  assign dmem0.instr = di;
  assign dmem0.addr  = da;
  assign dmem0.wdata = dw;
  assign dmem0.wstrb = dstb;
  assign mem0.rdata  = mrd;
  assign mem0.ready  = mr;

  assign imem1.valid = iv;
  assign imem1.instr = ii;
  assign imem1.addr  = ia;
  assign imem1.wdata = iw;
  assign imem1.wstrb = istb;
  assign dmem1.valid = dv;
  assign dmem1.instr = di;
  assign dmem1.addr  = da;
  assign dmem1.wdata = dw;
  assign dmem1.wstrb = dstb;
  assign mem1.rdata  = mrd;
  assign mem1.ready  = mr;

  bus_arbiter #(.RR(1)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .imemory (imem0),
    .dmemory (dmem0),
    .memory  (mem0)
  );

  bus_arbiter #(.RR(0)) u_fp (
    .clk     (clk),
    .rst     (rst),
    .imemory (imem1),
    .dmemory (dmem1),
    .memory  (mem1)
  );

  // Model: owner 0 = none, 1 = instruction, 2 = data.
  int          own [2];
  bit          lastd [2];
  logic        ex_instr [2];
  logic [31:0] ex_addr [2];
  logic [31:0] ex_wdata [2];
  logic [3:0]  ex_wstrb [2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_dut(input int k, input logic v, input logic in,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ir,
                         input logic dr, input logic [31:0] ird,
                         input logic [31:0] drd);
    string p;
    p = (k == 0) ? "rr" : "fp";
    chk({p, ".valid"}, 32'(v), 32'(own[k] != 0));
    chk({p, ".instr"}, 32'(in), 32'(ex_instr[k]));
    chk({p, ".addr"}, a, ex_addr[k]);
    chk({p, ".wdata"}, wd, ex_wdata[k]);
    chk({p, ".wstrb"}, 32'(ws), 32'(ex_wstrb[k]));
    chk({p, ".iready"}, 32'(ir), 32'(mr && own[k] == 1));
    chk({p, ".dready"}, 32'(dr), 32'(mr && own[k] == 2));
    chk({p, ".irdata"}, ird, mrd);
    chk({p, ".drdata"}, drd, mrd);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k]      = 0;
      lastd[k]    = 1'b1;
      ex_instr[k] = 1'b0;
      ex_addr[k]  = '0;
      ex_wdata[k] = '0;
      ex_wstrb[k] = '0;
    end
  endtask

  task automatic model_tick();
    int w;
    for (int k = 0; k < 2; k++) begin
      if (own[k] == 0) begin
        w = 0;
        if (iv && dv)
          w = (k == 0 && lastd[k]) ? 1 : 2;
        else if (iv)
          w = 1;
        else if (dv)
          w = 2;
        if (w == 1) begin
          ex_instr[k] = ii;
          ex_addr[k]  = ia;
          ex_wdata[k] = iw;
          ex_wstrb[k] = istb;
          lastd[k]    = 1'b0;
        end else if (w == 2) begin
          ex_instr[k] = di;
          ex_addr[k]  = da;
          ex_wdata[k] = dw;
          ex_wstrb[k] = dstb;
          lastd[k]    = 1'b1;
        end
        own[k] = w;
      end else if (mr) begin
        own[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk_dut(0, mem0.valid, mem0.instr, mem0.addr, mem0.wdata,
            mem0.wstrb, imem0.ready, dmem0.ready,
            imem0.rdata, dmem0.rdata);
    chk_dut(1, mem1.valid, mem1.instr, mem1.addr, mem1.wdata,
            mem1.wstrb, imem1.ready, dmem1.ready,
            imem1.rdata, dmem1.rdata);
  endtask

  // Inputs are set at negedge; check, predict, advance one cycle.
  task automatic step();
    #1;
    check_all();
    model_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_in();
    iv = 0; ii = 0; ia = '0; iw = '0; istb = '0;
    dv = 0; di = 0; da = '0; dw = '0; dstb = '0;
    mr = 0; mrd = '0;
  endtask

  initial begin
    clear_in();
    model_reset();
    @(negedge clk);
    mr = 1'b1;
    do_reset();
    mr = 1'b0;

    // Single instruction fetch.
    iv = 1; ii = 1; ia = 32'h100; istb = 4'h0;
    step();
    iv = 0;
    step();
    mr = 1; mrd = 32'hDEADBEEF;
    #1;
    chk("fetch.addr", mem0.addr, 32'h100);
    chk("fetch.iready", 32'(imem0.ready), 32'd1);
    chk("fetch.rdata", imem0.rdata, 32'hDEADBEEF);
    chk("fetch.dready", 32'(dmem0.ready), 32'd0);
    step();
    mr = 0;
    step();

    // Tie after reset, ready always high so every grant is one cycle.
    do_reset();
    iv = 1; ia = 32'h10; dv = 1; da = 32'h20; mr = 1;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr.grant", mem0.addr, (g % 2) ? 32'h20 : 32'h10);
      chk("fp.grant", mem1.addr, 32'h20);
      step();
    end
    clear_in();
    step();

    // Data write held stable until completion.
    dv = 1; da = 32'h80; dw = 32'h12345678; dstb = 4'hF;
    step();
    dv = 0;
    for (int c = 0; c < 2; c++) begin
      chk("wr.addr", mem0.addr, 32'h80);
      chk("wr.wdata", mem0.wdata, 32'h12345678);
      chk("wr.wstrb", 32'(mem0.wstrb), 32'hF);
      step();
    end
    mr = 1;
    #1;
    chk("wr.dready", 32'(dmem0.ready), 32'd1);
    step();
    mr = 0;
    step();

    // Reset while a data transaction is outstanding.
    dv = 1; da = 32'h44;
    step();
    dv = 0;
    step();
    do_reset();
    chk("rst.valid", 32'(mem0.valid), 32'd0);
    dv = 1; da = 32'h48;
    step();
    chk("rst.regrant", mem0.addr, 32'h48);
    clear_in();
    step();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        iv   = ($urandom_range(3) != 0);
        ii   = 1'($urandom);
        ia   = $urandom;
        iw   = $urandom;
        istb = 4'($urandom);
        dv   = ($urandom_range(3) != 0);
        di   = 1'($urandom);
        da   = $urandom;
        dw   = $urandom;
        dstb = 4'($urandom);
        mr   = ($urandom_range(2) == 0);
        mrd  = $urandom;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1, meaning 1 = round-robin tie-break and 0 = fixed data-port priority.
REQ-002 clk  in  1  single clock, rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 imemory_valid  in  1  instruction-port request.
REQ-005 imemory_instr  in  1  instruction-fetch flag.
REQ-006 imemory_addr  in  32  instruction-port address.
REQ-007 imemory_wdata  in  32  instruction-port write data.
REQ-008 imemory_wstrb  in  4  instruction-port byte strobes (0 = read).
REQ-009 imemory_rdata  out  32  instruction-port read data.
REQ-010 imemory_ready  out  1  instruction-port completion pulse.
REQ-011 dmemory_valid / dmemory_instr / dmemory_addr / dmemory_wdata / dmemory_wstrb  in  1/1/32/32/4  data-port request, same meanings as REQ-004..008.
REQ-012 dmemory_rdata  out  32  data-port read data.
REQ-013 dmemory_ready  out  1  data-port completion pulse.
REQ-014 memory_valid / memory_instr / memory_addr / memory_wdata / memory_wstrb  out  1/1/32/32/4  merged request to the shared memory.
REQ-015 memory_rdata  in  32  shared-memory read data.
REQ-016 memory_ready  in  1  shared-memory completion, one cycle per transaction.

Function
REQ-017 SHALL implement states IDLE, IBUSY, DBUSY; exactly one transaction outstanding at a time.
REQ-018 IDLE, only imemory_valid=1: SHALL register the instruction-port instr/addr/wdata/wstrb into the output registers and go to IBUSY.
REQ-019 IDLE, only dmemory_valid=1: SHALL register the data-port fields and go to DBUSY.
REQ-020 IDLE, both valid: RR=0 -> data port wins; RR=1 -> the port not recorded in last_grant wins.
REQ-021 last_grant SHALL update on every grant. Its reset value is "data", so the first tie goes to the instruction port.
REQ-022 memory_valid SHALL be 1 exactly while in IBUSY or DBUSY; memory_instr/addr/wdata/wstrb SHALL hold stable throughout.
REQ-023 Latency: a request sampled in IDLE at edge N SHALL drive memory_valid=1 from edge N onward (registered output, no combinational valid path).
REQ-024 imemory_rdata and dmemory_rdata SHALL both carry memory_rdata combinationally (broadcast).
REQ-025 imemory_ready SHALL equal memory_ready AND state==IBUSY; dmemory_ready SHALL equal memory_ready AND state==DBUSY. Both are combinational.
REQ-026 On memory_ready in IBUSY or DBUSY: the state SHALL return to IDLE at that edge and memory_valid SHALL drop the next cycle.
REQ-027 A port valid still high in the IDLE cycle after its own ready SHALL be treated as a new request (one idle bubble between transactions).
REQ-028 A requestor dropping valid while its transaction is outstanding SHALL NOT abort it; the transaction completes and ready still pulses.
REQ-029 memory_ready while in IDLE SHALL be ignored: no port ready, no state change.
REQ-030 The non-granted port's ready SHALL stay 0. Its request SHALL be served in a later IDLE if still asserted.
REQ-031 Under RR=1 with both ports continuously requesting, grants SHALL strictly alternate I, D, I, D...

Reset
REQ-032 rst=0 SHALL asynchronously force: state IDLE, last_grant data, memory_valid 0, memory_instr 0, memory_addr 0, memory_wdata 0, memory_wstrb 0, both port readys 0.
REQ-033 Reset mid-transaction SHALL abandon it with no ready pulse. Operation resumes from IDLE on the first edge after rst=1.

Verification
REQ-034 Single fetch: imemory_valid=1, addr 0x100, wstrb 0; memory_ready with rdata 0xDEADBEEF two cycles later -> memory_addr=0x100; imemory_ready=1 with rdata 0xDEADBEEF; dmemory_ready=0.
REQ-035 Tie after reset, RR=1: both valid (I 0x10, D 0x20) -> first grant 0x10 (IBUSY), second grant 0x20, third grant 0x10 -> alternation.
REQ-036 Tie, RR=0: both valid continuously -> every grant goes to data addr 0x20; instruction starves while dmemory_valid stays high.
REQ-037 Data write: dmemory addr 0x80, wdata 0x12345678, wstrb 0xF -> memory outputs carry exactly these values stable until memory_ready; dmemory_ready pulses 1 cycle.
REQ-038 Reset mid-transaction: assert rst=0 in DBUSY before memory_ready -> memory_valid=0 immediately; no dmemory_ready; next request granted normally.
REQ-039 Spurious memory_ready=1 in IDLE -> both port readys 0 and state remains IDLE.
